// File: rtl/interp_vector_unit.sv
// Linear interpolation over RAM vectors: out[i] = un[i] + r*(uz[i]-un[i]), r=(tk-tn)/(tz-tn).
// Build option: define INTERP_SATURATE_EN to clamp out-of-range results instead of wrapping.
module interp_vector_unit #(
    parameter int WORD_SIZE     = 16,
    parameter int FRAC_BITS     = 7,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DIM_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_sg,
    input  logic [WORD_SIZE-1:0]     tn_port,
    input  logic [WORD_SIZE-1:0]     tz_port,
    input  logic [WORD_SIZE-1:0]     tk_port,
    input  logic [DIM_WIDTH-1:0]     dim_port,
    input  logic [ADDRESS_WIDTH-1:0] un_base,
    input  logic [ADDRESS_WIDTH-1:0] uz_base,
    input  logic [ADDRESS_WIDTH-1:0] out_base,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [WORD_SIZE-1:0]     ram_wdata,
    input  logic [WORD_SIZE-1:0]     ram_rdata,
    output logic                     busy,
    output logic                     done_sg,
    output logic                     overflow,
    output logic                     div_zero
);

    localparam int DW = WORD_SIZE + FRAC_BITS;
    localparam int CW = $clog2(DW);
    localparam int PW = 2 * WORD_SIZE + 1;
    localparam int SW = PW + 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    localparam logic [DW-1:0] QMAX_P = DW'(2 ** (WORD_SIZE - 1) - 1);
    localparam logic [DW-1:0] QMAX_N = DW'(2 ** (WORD_SIZE - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_RD_UN, S_RD_UZ, S_CALC, S_WR, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]               cnt_q;
    logic [DW-1:0]               dq_q;
    logic [WORD_SIZE-1:0]        rem_q;
    logic [WORD_SIZE-1:0]        den_q;
    logic                        neg_q;
    logic                        dz_q;
    logic signed [WORD_SIZE-1:0] r_q;
    logic [DIM_WIDTH-1:0]        m_q;
    logic [DIM_WIDTH-1:0]        i_q;
    logic [ADDRESS_WIDTH-1:0]    un_base_q;
    logic [ADDRESS_WIDTH-1:0]    uz_base_q;
    logic [ADDRESS_WIDTH-1:0]    out_base_q;
    logic signed [WORD_SIZE-1:0] un_q;
    logic [WORD_SIZE-1:0]        res_q;
    logic                        ovf_q;
    logic                        divz_q;
    logic                        done_q;

    logic signed [WORD_SIZE:0]   num_w, den_w;
    logic [WORD_SIZE:0]          num_mag, den_mag;
    logic [WORD_SIZE:0]          rem_sh, rem_sub;
    logic                        ge;
    logic [WORD_SIZE-1:0]        rem_nx;
    logic [DW-1:0]               q_nx;
    logic signed [WORD_SIZE-1:0] r_nx;
    logic                        q_ovf;
    logic signed [WORD_SIZE:0]   diff_w;
    logic signed [PW-1:0]        prod_w, shr_w;
    logic signed [SW-1:0]        sum_w;
    logic [SW-WORD_SIZE:0]       hi_w;
    logic                        in_range;
    logic [WORD_SIZE-1:0]        res_nx;
    logic                        last_el;

    // Operand magnitudes, computed straight from the ports on accept.
    always_comb begin
        num_w = $signed({tk_port[WORD_SIZE-1], tk_port})
              - $signed({tn_port[WORD_SIZE-1], tn_port});
        den_w = $signed({tz_port[WORD_SIZE-1], tz_port})
              - $signed({tn_port[WORD_SIZE-1], tn_port});
        num_mag = num_w[WORD_SIZE] ? -num_w : num_w;
        den_mag = den_w[WORD_SIZE] ? -den_w : den_w;
    end

    // One restoring step per cycle; quotient bits shift into dq_q.
    always_comb begin
        rem_sh  = {rem_q, dq_q[DW-1]};
        ge      = rem_sh >= {1'b0, den_q};
        rem_sub = rem_sh - {1'b0, den_q};
        rem_nx  = ge ? WORD_SIZE'(rem_sub) : WORD_SIZE'(rem_sh);
        q_nx    = {dq_q[DW-2:0], ge};
        r_nx    = '0;
        q_ovf   = 1'b0;
        if (dz_q) begin
            r_nx = '0;
        end else if (neg_q) begin
            if (q_nx > QMAX_N) begin
                r_nx  = {1'b1, {(WORD_SIZE-1){1'b0}}};
                q_ovf = 1'b1;
            end else begin
                r_nx = WORD_SIZE'(-q_nx);
            end
        end else if (q_nx > QMAX_P) begin
            r_nx  = {1'b0, {(WORD_SIZE-1){1'b1}}};
            q_ovf = 1'b1;
        end else begin
            r_nx = WORD_SIZE'(q_nx);
        end
    end

    always_comb begin
        diff_w = $signed({ram_rdata[WORD_SIZE-1], ram_rdata})
               - $signed({un_q[WORD_SIZE-1], un_q});
        prod_w = PW'(r_q) * PW'(diff_w);
        shr_w  = prod_w >>> FRAC_BITS;
        sum_w  = SW'(shr_w) + SW'(un_q);
        hi_w   = sum_w[SW-1:WORD_SIZE-1];
        in_range = (&hi_w) | ~(|hi_w);
`ifdef INTERP_SATURATE_EN
        if (in_range)
            res_nx = sum_w[WORD_SIZE-1:0];
        else if (sum_w[SW-1])
            res_nx = {1'b1, {(WORD_SIZE-1){1'b0}}};
        else
            res_nx = {1'b0, {(WORD_SIZE-1){1'b1}}};
`else
        res_nx = sum_w[WORD_SIZE-1:0];
`endif
    end

    assign last_el = (i_q == m_q - DIM_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_sg)
                         state_d = (dim_port != '0) ? S_DIV : S_DONE;
            S_DIV:   if (cnt_q == LAST) state_d = S_RD_UN;
            S_RD_UN: state_d = S_RD_UZ;
            S_RD_UZ: state_d = S_CALC;
            S_CALC:  state_d = S_WR;
            S_WR:    state_d = last_el ? S_DONE : S_RD_UN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_addr = '0;
        unique case (state_q)
            S_RD_UN: ram_addr = un_base_q + ADDRESS_WIDTH'(i_q);
            S_RD_UZ: ram_addr = uz_base_q + ADDRESS_WIDTH'(i_q);
            S_WR:    ram_addr = out_base_q + ADDRESS_WIDTH'(i_q);
            default: ram_addr = '0;
        endcase
        ram_we    = (state_q == S_WR);
        ram_wdata = ram_we ? res_q : '0;
    end

    assign busy     = (state_q != S_IDLE);
    assign done_sg  = done_q;
    assign overflow = ovf_q;
    assign div_zero = divz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            den_q      <= '0;
            neg_q      <= 1'b0;
            dz_q       <= 1'b0;
            r_q        <= '0;
            m_q        <= '0;
            i_q        <= '0;
            un_base_q  <= '0;
            uz_base_q  <= '0;
            out_base_q <= '0;
            un_q       <= '0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            divz_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            unique case (state_q)
                S_IDLE: if (start_sg) begin
                    m_q        <= dim_port;
                    un_base_q  <= un_base;
                    uz_base_q  <= uz_base;
                    out_base_q <= out_base;
                    dq_q       <= DW'({num_mag, {FRAC_BITS{1'b0}}});
                    den_q      <= WORD_SIZE'(den_mag);
                    rem_q      <= '0;
                    cnt_q      <= '0;
                    neg_q      <= num_w[WORD_SIZE] ^ den_w[WORD_SIZE];
                    dz_q       <= (den_w == '0);
                    i_q        <= '0;
                    ovf_q      <= 1'b0;
                    divz_q     <= 1'b0;
                end
                S_DIV: begin
                    dq_q  <= q_nx;
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        r_q    <= r_nx;
                        ovf_q  <= ovf_q | q_ovf;
                        divz_q <= dz_q;
                        i_q    <= '0;
                    end
                end
                S_RD_UZ: un_q <= ram_rdata;
                S_CALC: begin
                    res_q <= res_nx;
                    if (!in_range) ovf_q <= 1'b1;
                end
                S_WR: if (!last_el) i_q <= i_q + DIM_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule
